// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with the architectural HI/LO pair.
// MULT/MULTU/DIV/DIVU latch their operands at Start and write HI/LO after a
// fixed latency. MTHI/MTLO write in the same cycle with no busy time.
// The result is formed combinationally from the latched operands and is only
// committed on the final cycle of the operation's latency window.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      a_reg, a_next;
  logic [31:0]      b_reg, b_next;
  logic             sgn_reg, sgn_next;
  logic [31:0]      hi_reg, hi_next;
  logic [31:0]      lo_reg, lo_next;
  logic             busy_reg, busy_next;

  // Datapath signals derived from the latched operands only
  logic [63:0] mul_a, mul_b, prod;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] uquot, urem, quot, rem;
  logic        finish;

  // Arithmetic on latched operands: 64-bit product and sign-corrected divide
  always_comb begin
    mul_a    = {{32{sgn_reg & a_reg[31]}}, a_reg};
    mul_b    = {{32{sgn_reg & b_reg[31]}}, b_reg};
    prod     = mul_a * mul_b;

    a_neg    = sgn_reg & a_reg[31];
    b_neg    = sgn_reg & b_reg[31];
    a_mag    = a_neg ? (~a_reg + 32'd1) : a_reg;
    b_mag    = b_neg ? (~b_reg + 32'd1) : b_reg;
    div_zero = (b_reg == 32'd0);
    // Substitute a harmless divisor so the divider never sees zero; the
    // result is discarded in that case anyway.
    b_safe   = div_zero ? 32'd1 : b_mag;
    uquot    = a_mag / b_safe;
    urem     = a_mag % b_safe;
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
    quot     = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
    rem      = a_neg ? (~urem + 32'd1) : urem;
  end

  // Next-state, counter, operand latch and HI/LO update
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    sgn_next   = sgn_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    busy_next  = busy_reg;
    finish     = 1'b0;

    case (state_reg)
      ST_MUL: begin
        if (cnt_reg == CNT_ONE) begin
          finish     = 1'b1;
          hi_next    = prod[63:32];
          lo_next    = prod[31:0];
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      ST_DIV: begin
        if (cnt_reg == CNT_ONE) begin
          finish = 1'b1;
          if (!div_zero) begin
            hi_next = rem;
            lo_next = quot;
          end
          state_next = ST_IDLE;
          busy_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A new Start is taken when idle or on the very edge the current
    // operation completes, so back-to-back issue costs no extra cycle.
    // A later MTHI/MTLO on the completion edge overrides the result it targets.
    if (Start && ((state_reg == ST_IDLE) || finish)) begin
      case (Op)
        OP_MULT, OP_MULTU: begin
          a_next     = A;
          b_next     = B;
          sgn_next   = (Op == OP_MULT);
          cnt_next   = CNT_MULT;
          state_next = ST_MUL;
          busy_next  = 1'b1;
        end
        OP_DIV, OP_DIVU: begin
          a_next     = A;
          b_next     = B;
          sgn_next   = (Op == OP_DIV);
          cnt_next   = CNT_DIV;
          state_next = ST_DIV;
          busy_next  = 1'b1;
        end
        OP_MTHI: hi_next = A;
        OP_MTLO: lo_next = A;
        default: ;
      endcase
    end
  end

  // State register; reset aborts any operation without writing a result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      sgn_reg   <= sgn_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      busy_reg  <= busy_next;
    end
  end

  assign Busy = busy_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed-vector bench for md_unit with hand-computed results.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  Op = 3'd6;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;

  // Bench-side copy of the architectural HI/LO for hold checks during Busy
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Op    (Op),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // Absolute time bound in case anything stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary line");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
    end
  endtask

  // Drive a Start for one rising edge; returns just after that edge (t0)
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Op = op; A = a; B = b; Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0; Op = 3'd6;
    A = $urandom; B = $urandom;
  endtask

  // MTHI (sel_hi=1) or MTLO: zero-latency write
  task automatic mt_op(input string tag, input bit sel_hi, input logic [31:0] v);
    start_op(sel_hi ? 3'd4 : 3'd5, v, 32'h0);
    if (sel_hi) hi_m = v; else lo_m = v;
    @(negedge clk);
    check({tag, "_busy"}, {31'b0, Busy}, 32'd0);
    check({tag, "_hi"}, HI, hi_m);
    check({tag, "_lo"}, LO, lo_m);
    $display("txn %s op=%0d a=%08h -> hi=%08h lo=%08h", tag, sel_hi ? 4 : 5, v, HI, LO);
  endtask

  // Multi-cycle op: Busy for n edges, HI/LO held, then result with Busy low.
  // inj >= 0 drives an MTLO Start at that point inside the busy window.
  task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input int inj,
                        input logic [31:0] ehi, input logic [31:0] elo);
    start_op(op, a, b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_busy_hi"}, {31'b0, Busy}, 32'd1);
      if (i == 0 || i == n - 1) begin
        check({tag, "_hold_hi"}, HI, hi_m);
        check({tag, "_hold_lo"}, LO, lo_m);
      end
      A = $urandom; B = $urandom;
      if (i == inj) begin
        Start = 1'b1; Op = 3'd5; A = 32'hDEADBEEF;
      end else begin
        Start = 1'b0; Op = 3'd6;
      end
    end
    @(negedge clk);
    check({tag, "_busy_lo"}, {31'b0, Busy}, 32'd0);
    check({tag, "_hi"}, HI, ehi);
    check({tag, "_lo"}, LO, elo);
    hi_m = ehi; lo_m = elo;
    $display("txn %s op=%0d a=%08h b=%08h -> hi=%08h lo=%08h", tag, op, a, b, HI, LO);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b1;

    mt_op("mthi0", 1'b1, 32'hAAAA5555);
    mt_op("mtlo0", 1'b0, 32'h5555AAAA);

    // Async reset in the middle of a MULT, at counter=3
    start_op(3'd0, 32'd7, 32'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_busy_pre", {31'b0, Busy}, 32'd1);
    end
    #2 reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    $display("txn abort mult 7*9 by reset -> hi=%08h lo=%08h busy=%0d", HI, LO, Busy);
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    reset = 1'b1;

    run_md("multu_2x3",  3'd1, 32'd2,        32'd3,        5,  -1, 32'h00000000, 32'h00000006);
    run_md("mult_m2x3",  3'd0, 32'hFFFFFFFE, 32'd3,        5,  -1, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_md("multu_max",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  -1, 32'hFFFFFFFE, 32'h00000001);
    run_md("div_m7_2",   3'd2, 32'hFFFFFFF9, 32'd2,        10, -1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu_m7_2",  3'd3, 32'hFFFFFFF9, 32'd2,        10, -1, 32'h00000001, 32'h7FFFFFFC);
    run_md("div_ovf",    3'd2, 32'h80000000, 32'hFFFFFFFF, 10, -1, 32'h00000000, 32'h80000000);

    // Divide by zero keeps HI/LO; an MTLO Start mid-window is ignored
    mt_op("mthi1", 1'b1, 32'h12345678);
    mt_op("mtlo1", 1'b0, 32'h9ABCDEF0);
    run_md("div_by0",    3'd2, 32'd55,       32'd0,        10, 3,  32'h12345678, 32'h9ABCDEF0);

    // Back-to-back: MULT 3*4, DIVU 100/7 issued on the edge Busy falls
    start_op(3'd0, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_mul_busy", {31'b0, Busy}, 32'd1);
      A = $urandom; B = $urandom;
      if (i == 4) begin
        Start = 1'b1; Op = 3'd3; A = 32'd100; B = 32'd7;
      end
    end
    @(negedge clk);
    check("b2b_mul_lo", LO, 32'd12);
    check("b2b_mul_hi", HI, 32'd0);
    check("b2b_div_busy0", {31'b0, Busy}, 32'd1);
    $display("txn b2b mult 3*4 -> hi=%08h lo=%08h", HI, LO);
    Start = 1'b0; Op = 3'd6; A = $urandom; B = $urandom;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("b2b_div_busy", {31'b0, Busy}, 32'd1);
      check("b2b_div_hold_lo", LO, 32'd12);
      A = $urandom; B = $urandom;
    end
    @(negedge clk);
    check("b2b_div_done", {31'b0, Busy}, 32'd0);
    check("b2b_div_lo", LO, 32'd14);
    check("b2b_div_hi", HI, 32'd2);
    $display("txn b2b divu 100/7 -> hi=%08h lo=%08h", HI, LO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS core. It consumes the two EX-stage operands: A is the forwarded rs value; B is the forwarded rt value or the 32-bit sign/zero-extended immediate. It executes MULT/MULTU/DIV/DIVU/MTHI/MTLO and holds the architectural HI/LO registers. While `Start` or `Busy` is high, the hazard unit stalls any MD-class instruction in ID.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles from Start to result for MULT/MULTU (≥1)
- DIV_CYCLES, 10, cycles from Start to result for DIV/DIVU (≥1)

Ports:
- clk  input  1  rising-edge clock; one clock domain
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
- A  input  32  operand 1 (rs / dividend)
- B  input  32  operand 2 (rt or extended immediate / divisor)
- Op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6–7=no-op
- Start  input  1  qualifies Op for one cycle; sampled on rising clk
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, MUL, DIV. Reset → IDLE, Busy=0, HI=0, LO=0, counter=0.
- IDLE, Start=1:
  - Op 0/1: latch A, B and the signedness, load counter=MULT_CYCLES, go to MUL, set Busy=1.
  - Op 2/3: latch A, B and the signedness, load counter=DIV_CYCLES, go to DIV, set Busy=1.
  - Op 4: HI←A at this edge. Op 5: LO←A at this edge. Both stay in IDLE with Busy=0.
  - Op 6/7: no effect.
- MUL/DIV: decrement the counter each cycle. When the counter reaches 1, at the next edge:
  - write HI/LO,
  - go to IDLE,
  - clear Busy.
- Start while Busy=1 (any Op): ignored. Latched operands, counter and HI/LO are unchanged. The hazard unit guarantees this never occurs; the bench still checks it.
- Operands are latched at Start. Changes on A/B during Busy have no effect.
- Arithmetic:
  - MULT: {HI,LO} = signed 32×32 → 64-bit product.
  - MULTU: {HI,LO} = unsigned 32×32 → 64-bit product.
  - DIV: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
  - Divide by zero (B=0, DIV or DIVU): the full DIV_CYCLES latency still elapses; HI and LO are left unchanged.
- The implementation is free to compute the result combinationally from the latched operands, iteratively, or in a pipeline. Only the latency and the final values are specified.
- Reset (reset=0) mid-operation aborts at once: IDLE, Busy=0, HI=LO=0. No partial result is written.

## Timing
- Start sampled at edge t0 (MULT/DIV class):
  - Busy=1 after t0 through edge t0+N−1, where N = MULT_CYCLES or DIV_CYCLES.
  - At edge t0+N: HI/LO take the result and Busy=0, both at the same edge.
- A new Start is accepted at edge t0+N, the same edge Busy falls. Back-to-back operations therefore issue every N cycles.
- MTHI/MTLO take effect at the sampling edge, with zero busy cycles.
- HI, LO and Busy are registered outputs with no combinational path from the inputs.
- Reads of HI/LO (MFHI/MFLO) are valid whenever Busy=0. During Busy, HI/LO hold their pre-operation values.
- Async reset assertion clears outputs without a clock edge. Deassertion is synchronised externally; the first Start is honoured on the first rising edge with reset=1.

## Test plan
- Reset: hold reset=0 mid-MULT, at counter=3 → Busy=0, HI=LO=0 immediately, with no clock edge. After release, a MULTU of 2×3 → LO=6, HI=0.
- MULT signed: A=0xFFFFFFFE (−2), B=3, Start at t0 → Busy=1 for edges t0..t0+4. At t0+5: HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
- MULTU: A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, 5 cycles.
- DIV/DIVU:
  - DIV A=−7 (0xFFFFFFF9), B=2 → after 10 cycles LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - DIVU of the same operands → LO=0x7FFFFFFC, HI=1.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero and ignored Start:
  - MTHI A=0x12345678, then MTLO A=0x9ABCDEF0, then DIV B=0 → Busy for 10 cycles; HI/LO unchanged (0x12345678 / 0x9ABCDEF0).
  - A Start of MTLO during that Busy window is ignored.
- Back-to-back and operand stability:
  - MULT 3×4, then Start DIVU 100/7 on the same edge Busy falls → LO=12 at t0+5, then LO=14, HI=2 at t0+15.
  - Toggle A/B randomly during Busy → results unaffected.
